alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one combinational ALU (32-bit, 3-bit ALUCtrl, Zero flag) between NUM_REQ requesters.
//   Round-robin arbitration, valid/ready on both request and response sides.
//   Sequences each op as ACCEPT -> ISSUE -> RESP. Sits between the EX-stage / auxiliary units and the ALU.
// PARAMETERS
//   NUM_REQ   2    number of requesters (2..4)
//   DATA_W    32   operand/result width
//   CTRL_W    3    ALU control width
// PORTS
//   clk_i          in   1                 clock; all state updates on rising edge
//   rst_i          in   1                 reset, asynchronous, active-low
//   req_valid_i    in   NUM_REQ           per-requester request valid
//   req_ready_o    out  NUM_REQ           per-requester accept (one-hot or zero)
//   req_ctrl_i     in   NUM_REQ*CTRL_W    flattened ALU ops; requester k at [k*CTRL_W +: CTRL_W]
//   req_a_i        in   NUM_REQ*DATA_W    flattened operand A
//   req_b_i        in   NUM_REQ*DATA_W    flattened operand B
//   rsp_valid_o    out  NUM_REQ           result valid, one-hot to the owning requester
//   rsp_ready_i    in   NUM_REQ           per-requester result accept
//   rsp_data_o     out  DATA_W            result (shared bus, qualified by rsp_valid_o)
//   rsp_zero_o     out  1                 Zero flag of result
//   alu_data1_o    out  DATA_W            to ALU data1
//   alu_data2_o    out  DATA_W            to ALU data2
//   alu_ctrl_o     out  CTRL_W            to ALU control
//   alu_data_i     in   DATA_W            from ALU result
//   alu_zero_i     in   1                 from ALU Zero
//   busy_o         out  1                 high whenever state != IDLE
// BEHAVIOUR
//   FSM states: IDLE, ISSUE, RESP.
//   - IDLE: if |req_valid_i, pick winner w by round-robin starting at last_grant+1 (mod NUM_REQ).
//     req_ready_o[w]=1 combinationally in the same cycle; op/A/B latched into op_q/a_q/b_q; grant_q<=w; -> ISSUE.
//     No valid: stay IDLE, req_ready_o=0.
//   - ISSUE: alu_* driven from op_q/a_q/b_q. alu_data_i/alu_zero_i captured into res_q/zero_q at end of cycle; -> RESP.
//   - RESP: rsp_valid_o = one-hot(grant_q); rsp_data_o=res_q; rsp_zero_o=zero_q.
//     On rsp_ready_i[grant_q]: last_grant<=grant_q; -> IDLE. Otherwise hold; outputs stable.
//   Latency: accept at cycle T, rsp_valid_o high from T+2. Max throughput one op per 3 cycles.
//   req_ready_o = 0 in ISSUE and RESP. rsp_ready_i of non-owning requesters ignored.
//   alu_* outputs are registered (op_q/a_q/b_q) and hold last values between ops.
//   Reset (async, any state, including mid-op): state=IDLE; all outputs 0; op_q/a_q/b_q/res_q/zero_q=0;
//     last_grant=NUM_REQ-1, so requester 0 wins the first contest. In-flight op discarded, no response.
//   Protocol: requester holds valid/ctrl/A/B until ready. Arbiter latches at accept and never re-samples.
//   Arithmetic: none in arbiter; result width DATA_W exactly as ALU returns (MUL truncated to low DATA_W).
// CONFIGURATION
//   ALU_ARB_OPCHK_EN defined:
//     - op latched at accept is checked against legal set {AND, OR, ADD, SUB, MUL}.
//     - Illegal op: ISSUE still runs; RESP returns rsp_data_o=0, rsp_zero_o=0 and rsp_err_o=1.
//     - Extra port: rsp_err_o  out  1, qualified by rsp_valid_o; 0 at reset.
//   ALU_ARB_OPCHK_EN undefined: no rsp_err_o; any op passed through unchanged (ALU default passes data1).
// STRUCTURE
//   Shared include alu_defs.vh:
//     - localparams ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_MUL=3'b101
//     - FSM encodings ST_IDLE/ST_ISSUE/ST_RESP
//   Sub-module rr_picker:
//     - combinational; inputs req vector, last_grant; outputs one-hot grant + index
// TESTING
//   1 Single req0 ADD A=5 B=7, rsp_ready_i=1 -> ready0 at T, rsp_valid_o=01 at T+2, data=12, zero=0.
//   2 Both valid from reset, req0 SUB 9-9, req1 OR 0xF0|0x0F -> req0 first (data 0, zero=1); req1 next (0xFF). Repeated contention alternates 0,1,0,1.
//   3 RESP with rsp_ready_i low 5 cycles -> rsp_valid/data held stable, req_ready_o=0 throughout; completes on ready.
//   4 rst_i low during ISSUE -> outputs 0 immediately; after release, req1 alone -> granted, no stale response.
//   5 MUL 0x10000*0x10000 -> data 0, zero=1 (truncation).
//   6 (OPCHK_EN) op 3'b111 -> rsp_err_o=1, data 0. Without macro -> data = A.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU opcodes, FSM state
// encoding and the legal-opcode helper used by the optional op check
// (ALU_ARB_OPCHK_EN).
package alu_share_arbiter_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_e;

    // True for the five opcodes the shared ALU actually implements.
    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_MUL: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Combinational round-robin picker: searches the request vector starting
// one past the last grant and wrapping, returns one-hot grant and index.
module alu_share_arbiter_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               grant_any_o
);

    logic [IDX_W-1:0] cand;

    // First requester found after last_grant_i (mod NUM_REQ) wins.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
            if (!grant_any_o && req_i[cand]) begin
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
                grant_any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters with round-robin
// arbitration and valid/ready handshakes on both sides. Each op runs
// ACCEPT (in IDLE) -> ISSUE -> RESP.
// Optional feature macro: ALU_ARB_OPCHK_EN adds rsp_err_o and squashes the
// result of any opcode the ALU does not implement.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for requests; winner accepted combinationally
// ST_ISSUE | latched op on alu_*; ALU result captured at end of cycle
// ST_RESP  | result presented to owner until its rsp_ready_i
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      rsp_zero_o,
`ifdef ALU_ARB_OPCHK_EN
    output logic                      rsp_err_o,
`endif
    output logic [DATA_W-1:0]         alu_data1_o,
    output logic [DATA_W-1:0]         alu_data2_o,
    output logic [CTRL_W-1:0]         alu_ctrl_o,
    input  logic [DATA_W-1:0]         alu_data_i,
    input  logic                      alu_zero_i,
    output logic                      busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    last_grant_q;
    logic [CTRL_W-1:0]   op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   res_q;
    logic                zero_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
`ifdef ALU_ARB_OPCHK_EN
    logic                err_q;
    logic                op_illegal;
`endif

    logic [NUM_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [CTRL_W-1:0]   op_d;
    logic [DATA_W-1:0]   a_d;
    logic [DATA_W-1:0]   b_d;

    alu_share_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (pick_oh),
        .grant_idx_o  (pick_idx),
        .grant_any_o  (pick_any)
    );

    // Select the winning requester's op and operands for latching at accept.
    always_comb begin
        op_d = '0;
        a_d  = '0;
        b_d  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_oh[k]) begin
                op_d = req_ctrl_i[k*CTRL_W +: CTRL_W];
                a_d  = req_a_i[k*DATA_W +: DATA_W];
                b_d  = req_b_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Accept is same-cycle; reset gates it so nothing looks accepted in reset.
    always_comb begin
        req_ready_o = '0;
        if (rst_i && (state_q == ST_IDLE)) begin
            req_ready_o = pick_oh;
        end
    end

`ifdef ALU_ARB_OPCHK_EN
    assign op_illegal = !is_legal_op(op_q);
`endif

    // Sequencer: latches the winner, captures the ALU result, holds the response.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            rsp_valid_q  <= '0;
`ifdef ALU_ARB_OPCHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_q    <= op_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        grant_q <= pick_idx;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef ALU_ARB_OPCHK_EN
                    res_q  <= op_illegal ? '0   : alu_data_i;
                    zero_q <= op_illegal ? 1'b0 : alu_zero_i;
                    err_q  <= op_illegal;
`else
                    res_q  <= alu_data_i;
                    zero_q <= alu_zero_i;
`endif
                    rsp_valid_q <= NUM_REQ'(1) << grant_q;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i[grant_q]) begin
                        last_grant_q <= grant_q;
                        rsp_valid_q  <= '0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= '0;
                end
            endcase
        end
    end

    assign alu_ctrl_o  = op_q;
    assign alu_data1_o = a_q;
    assign alu_data2_o = b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = res_q;
    assign rsp_zero_o  = zero_q;
`ifdef ALU_ARB_OPCHK_EN
    assign rsp_err_o   = err_q;
`endif
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int NR  = 2;
    localparam int DW  = 32;
    localparam int CW  = 3;
    localparam int INF = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid_i = '0;
    logic [NR-1:0]     req_ready_o;
    logic [NR*CW-1:0]  req_ctrl_i = '0;
    logic [NR*DW-1:0]  req_a_i = '0;
    logic [NR*DW-1:0]  req_b_i = '0;
    logic [NR-1:0]     rsp_valid_o;
    logic [NR-1:0]     rsp_ready_i = '0;
    logic [DW-1:0]     rsp_data_o;
    logic              rsp_zero_o;
    logic              rsp_err_o;
    logic [DW-1:0]     alu_data1_o, alu_data2_o, alu_data_i;
    logic [CW-1:0]     alu_ctrl_o;
    logic              alu_zero_i;
    logic              busy_o;

    alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CTRL_W(CW)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_ctrl_i  (req_ctrl_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_zero_o  (rsp_zero_o),
`ifdef ALU_ARB_OPCHK_EN
        .rsp_err_o   (rsp_err_o),
`endif
        .alu_data1_o (alu_data1_o),
        .alu_data2_o (alu_data2_o),
        .alu_ctrl_o  (alu_ctrl_o),
        .alu_data_i  (alu_data_i),
        .alu_zero_i  (alu_zero_i),
        .busy_o      (busy_o)
    );

`ifndef ALU_ARB_OPCHK_EN
    assign rsp_err_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Behavioural ALU sitting behind the arbiter.
    always_comb begin
        case (alu_ctrl_o)
            3'b000:  alu_data_i = alu_data1_o & alu_data2_o;
            3'b001:  alu_data_i = alu_data1_o | alu_data2_o;
            3'b010:  alu_data_i = alu_data1_o + alu_data2_o;
            3'b110:  alu_data_i = alu_data1_o - alu_data2_o;
            3'b101:  alu_data_i = alu_data1_o * alu_data2_o;
            default: alu_data_i = alu_data1_o;
        endcase
        alu_zero_i = (alu_data_i == '0);
    end

    typedef struct {
        logic [CW-1:0] op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    typedef struct {
        int            idx;
        op_t           op;
        logic [DW-1:0] data;
        logic          zero;
        logic          err;
        int            start;
    } exp_t;

    exp_t          exp_q[$];
    op_t           s0[$];
    op_t           s1[$];
    op_t           cur[NR];
    logic [NR-1:0] pend = '0;
    logic [NR-1:0] acc_flag = '0;
    int            cyc = 0;
    int            model_last = NR - 1;
    int            model_free = INF;
    bit            rdy_low = 0;
    int            rdy_pct = 100;
    int            n_chk = 0;
    int            n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expected result from the operation's definition.
    function automatic void ref_alu(input op_t o, output logic [DW-1:0] r,
                                    output logic z, output logic e);
        logic legal;
        legal = 1'b1;
        case (o.op)
            3'b000:  r = o.a & o.b;
            3'b001:  r = o.a | o.b;
            3'b010:  r = o.a + o.b;
            3'b110:  r = o.a - o.b;
            3'b101:  r = DW'(o.a * o.b);
            default: begin r = o.a; legal = 1'b0; end
        endcase
        z = (r == '0);
        e = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
        if (!legal) begin
            r = '0;
            z = 1'b0;
            e = 1'b1;
        end
`endif
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int i = 1; i <= NR; i++) begin
            if (v[(last + i) % NR]) return (last + i) % NR;
        end
        return -1;
    endfunction

    // Stimulus side: predict the grant and push the expected response.
    int            w_c;
    logic [NR-1:0] rdy_exp;
    exp_t          e_new;
    always @(negedge clk) begin
        if (rst_n) begin
            rdy_exp = '0;
            w_c = -1;
            if (cyc >= model_free) w_c = rr_pick(req_valid_i, model_last);
            if (w_c >= 0) rdy_exp[w_c] = 1'b1;
            chk("req_ready", 64'(req_ready_o), 64'(rdy_exp));
            if (w_c >= 0) begin
                e_new.idx   = w_c;
                e_new.op    = cur[w_c];
                e_new.start = cyc + 2;
                ref_alu(cur[w_c], e_new.data, e_new.zero, e_new.err);
                exp_q.push_back(e_new);
                acc_flag[w_c] = 1'b1;
                model_free = INF;
            end
        end
    end

    // Monitor: compares presented responses against the scoreboard.
    logic [NR-1:0] v_exp;
    logic          b_exp;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
            chk("rst_req_ready", 64'(req_ready_o), 64'(0));
            chk("rst_busy", 64'(busy_o), 64'(0));
            chk("rst_rsp_data", 64'(rsp_data_o), 64'(0));
            chk("rst_rsp_zero", 64'(rsp_zero_o), 64'(0));
            chk("rst_rsp_err", 64'(rsp_err_o), 64'(0));
            chk("rst_alu_ctrl", 64'(alu_ctrl_o), 64'(0));
            chk("rst_alu_a", 64'(alu_data1_o), 64'(0));
            chk("rst_alu_b", 64'(alu_data2_o), 64'(0));
        end else begin
            v_exp = '0;
            b_exp = 1'b0;
            if (exp_q.size() > 0) begin
                b_exp = (cyc >= exp_q[0].start - 1);
                if (cyc >= exp_q[0].start) v_exp[exp_q[0].idx] = 1'b1;
                if (cyc == exp_q[0].start - 1) begin
                    chk("alu_ctrl", 64'(alu_ctrl_o), 64'(exp_q[0].op.op));
                    chk("alu_a", 64'(alu_data1_o), 64'(exp_q[0].op.a));
                    chk("alu_b", 64'(alu_data2_o), 64'(exp_q[0].op.b));
                end
            end
            chk("busy", 64'(busy_o), 64'(b_exp));
            chk("rsp_valid", 64'(rsp_valid_o), 64'(v_exp));
            if (v_exp != '0) begin
                chk("rsp_data", 64'(rsp_data_o), 64'(exp_q[0].data));
                chk("rsp_zero", 64'(rsp_zero_o), 64'(exp_q[0].zero));
`ifdef ALU_ARB_OPCHK_EN
                chk("rsp_err", 64'(rsp_err_o), 64'(exp_q[0].err));
`endif
                if (rsp_ready_i[exp_q[0].idx]) begin
                    model_last = exp_q[0].idx;
                    model_free = cyc + 1;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Advance one cycle and drive inputs just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (acc_flag[k]) begin
                pend[k] = 1'b0;
                acc_flag[k] = 1'b0;
            end
            if (!pend[k]) begin
                if (k == 0 && s0.size() > 0) begin
                    cur[k] = s0.pop_front();
                    pend[k] = 1'b1;
                end else if (k == 1 && s1.size() > 0) begin
                    cur[k] = s1.pop_front();
                    pend[k] = 1'b1;
                end
            end
            req_valid_i[k] = pend[k];
            if (pend[k]) begin
                req_ctrl_i[k*CW +: CW] = cur[k].op;
                req_a_i[k*DW +: DW]    = cur[k].a;
                req_b_i[k*DW +: DW]    = cur[k].b;
            end else begin
                req_ctrl_i[k*CW +: CW] = CW'($urandom);
                req_a_i[k*DW +: DW]    = $urandom;
                req_b_i[k*DW +: DW]    = $urandom;
            end
        end
        for (int k = 0; k < NR; k++) begin
            rsp_ready_i[k] = !rdy_low && ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic push(input int k, input logic [CW-1:0] op,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_t o;
        o.op = op;
        o.a = a;
        o.b = b;
        if (k == 0) s0.push_back(o);
        else s1.push_back(o);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (exp_q.size() == 0 && pend == '0 && acc_flag == '0 &&
                s0.size() == 0 && s1.size() == 0) done = 1;
            else step();
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: timeout after %0d cycles, %0d responses outstanding",
                     budget, exp_q.size());
        end
    endtask

    // Assert reset now (asynchronously) and release it a few cycles later.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        exp_q.delete();
        pend = '0;
        acc_flag = '0;
        s0.delete();
        s1.delete();
        model_free = INF;
        req_valid_i = '0;
        repeat (cycles) step();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_last = NR - 1;
        model_free = cyc;
    endtask

    initial begin
        do_reset(3);

        // single ADD
        rdy_pct = 100;
        push(0, 3'b010, 32'd5, 32'd7);
        wait_idle(50);

        // contention from a fresh reset, then repeated contention
        do_reset(2);
        push(0, 3'b110, 32'd9, 32'd9);
        push(1, 3'b001, 32'hF0, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            push(0, 3'b010, $urandom, $urandom);
            push(1, 3'b000, $urandom, $urandom);
        end
        wait_idle(100);

        // response back-pressure
        rdy_low = 1;
        push(0, 3'b000, 32'hDEAD_BEEF, 32'h0FF0_FF00);
        push(1, 3'b010, 32'd1, 32'd2);
        repeat (8) step();
        rdy_low = 0;
        wait_idle(50);

        // reset during ISSUE, then requester 1 alone
        push(0, 3'b010, 32'd1, 32'd2);
        begin
            int t;
            t = 0;
            while (exp_q.size() == 0 && t < 20) begin
                step();
                t++;
            end
            chk("reset_test_accept", 64'(exp_q.size()), 64'(1));
        end
        do_reset(2);
        push(1, 3'b010, 32'd100, 32'd23);
        wait_idle(50);

        // MUL truncation and unimplemented opcode
        push(0, 3'b101, 32'h0001_0000, 32'h0001_0000);
        push(1, 3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_idle(50);

        // randomized traffic with random back-pressure
        rdy_pct = 60;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 40 && s0.size() + s1.size() < 4) begin
                logic [DW-1:0] a;
                a = $urandom;
                push(int'($urandom_range(NR - 1)), CW'($urandom_range(7)), a,
                     ($urandom_range(3) == 0) ? a : $urandom);
            end
            step();
        end
        rdy_pct = 100;
        wait_idle(200);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
